// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - data-memory responder with handshaked requests, wait states and byte-lane stores
module dmem_responder #(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    localparam logic [3:0] LAT = 4'(LATENCY);

    state_t      state, state_nxt;
    logic [3:0]  cnt;
    logic        cap_we;
    logic [31:0] cap_addr, cap_wdata;
    logic [3:0]  cap_be;

    logic              accept, access;
    logic              acc_we, acc_err;
    logic [31:0]       acc_addr, acc_wdata;
    logic [3:0]        acc_be;
    logic [ADDR_W-1:0] acc_idx;

    logic [31:0] mem [2**ADDR_W];

    assign accept = req_valid && req_ready;
    assign access = (state_nxt == RESP) && (state != RESP);

    // With zero latency the access happens on the accept edge, so the live request is used
    always_comb begin
        if (state == IDLE) begin
            acc_we    = req_we;
            acc_addr  = req_addr;
            acc_wdata = req_wdata;
            acc_be    = req_be;
        end else begin
            acc_we    = cap_we;
            acc_addr  = cap_addr;
            acc_wdata = cap_wdata;
            acc_be    = cap_be;
        end
    end

    assign acc_err = (|acc_addr[1:0]) || (|acc_addr[31:ADDR_W+2]);
    assign acc_idx = acc_addr[ADDR_W+1:2];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req_valid) state_nxt = (LAT != 4'd0) ? WAIT : RESP;
            WAIT:    if (cnt == 4'd0) state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req_ready = reset && (state == IDLE);
        busy      = (state != IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt       <= 4'd0;
            cap_we    <= 1'b0;
            cap_addr  <= 32'd0;
            cap_wdata <= 32'd0;
            cap_be    <= 4'd0;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
        end else begin
            if (accept) begin
                cap_we    <= req_we;
                cap_addr  <= req_addr;
                cap_wdata <= req_wdata;
                cap_be    <= req_be;
                cnt       <= (LAT != 4'd0) ? LAT - 4'd1 : 4'd0;
            end else if (state == WAIT && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end

            if (access) begin
                rsp_valid <= 1'b1;
                rsp_err   <= acc_err;
                rsp_rdata <= (acc_we || acc_err) ? 32'd0 : mem[acc_idx];
            end else if (state == RESP && rsp_ready) begin
                rsp_valid <= 1'b0;
                rsp_err   <= 1'b0;
                rsp_rdata <= 32'd0;
            end
        end
    end

    // Array is deliberately not reset; the reset gate stops a zero-latency store committing mid-reset
    always_ff @(posedge clk) begin
        if (reset && access && acc_we && !acc_err) begin
            for (int i = 0; i < 4; i++) begin
                if (acc_be[i]) mem[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - directed bench for dmem_responder at LATENCY=2 (index 0) and LATENCY=0 (index 1)
module tb_dmem_responder;

    logic        clk;
    logic        rst       [2];
    logic        req_valid [2];
    logic        req_ready [2];
    logic        req_we    [2];
    logic [31:0] req_addr  [2];
    logic [31:0] req_wdata [2];
    logic [3:0]  req_be    [2];
    logic        rsp_valid [2];
    logic        rsp_ready [2];
    logic [31:0] rsp_rdata [2];
    logic        rsp_err   [2];
    logic        busy      [2];

    int pass_cnt  = 0;
    int check_cnt = 0;

    dmem_responder #(.ADDR_W(10), .LATENCY(2)) u_lat2 (
        .clk(clk), .reset(rst[0]),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
        .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_be(req_be[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_rdata(rsp_rdata[0]),
        .rsp_err(rsp_err[0]), .busy(busy[0])
    );

    dmem_responder #(.ADDR_W(10), .LATENCY(0)) u_lat0 (
        .clk(clk), .reset(rst[1]),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
        .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_be(req_be[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_rdata(rsp_rdata[1]),
        .rsp_err(rsp_err[1]), .busy(busy[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int lat_of(input int d);
        return (d == 0) ? 2 : 0;
    endfunction

    // Issues one request from IDLE, counts cycles to rsp_valid (bounded), then retires it
    task automatic do_req(input int d, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] be,
                          output logic [31:0] rdata, output logic err, output int n);
        @(negedge clk);
        req_valid[d] = 1'b1; req_we[d] = we; req_addr[d] = addr;
        req_wdata[d] = wdata; req_be[d] = be;
        @(posedge clk); #1;
        req_valid[d] = 1'b0;
        n = 1;
        while (rsp_valid[d] !== 1'b1 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        rdata = rsp_rdata[d];
        err   = rsp_err[d];
        rsp_ready[d] = 1'b1;
        @(posedge clk); #1;
        rsp_ready[d] = 1'b0;
    endtask

    task automatic test_reset();
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b0; req_valid[d] = 1'b0; req_we[d] = 1'b0; req_addr[d] = 32'd0;
            req_wdata[d] = 32'd0; req_be[d] = 4'd0; rsp_ready[d] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            check_cnt++;
            if (req_ready[d] !== 1'b0) $display("FAIL rst_ready_low[%0d] got %b want 0", d, req_ready[d]);
            else pass_cnt++;
        end
        @(negedge clk);
        rst[0] = 1'b1; rst[1] = 1'b1;
        #1;
        for (int d = 0; d < 2; d++) begin
            check_cnt++;
            if ({req_ready[d], rsp_valid[d], busy[d], rsp_err[d]} !== 4'b1000)
                $display("FAIL rst_ctl[%0d] got ready/valid/busy/err=%b want 1000", d,
                         {req_ready[d], rsp_valid[d], busy[d], rsp_err[d]});
            else pass_cnt++;
            check_cnt++;
            if (rsp_rdata[d] !== 32'd0) $display("FAIL rst_rdata[%0d] got %h want 0", d, rsp_rdata[d]);
            else pass_cnt++;
        end
    endtask

    task automatic test_store_load();
        logic [31:0] rd; logic er; int n;
        for (int d = 0; d < 2; d++) begin
            do_req(d, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd, er, n);
            check_cnt++;
            if ({er, rd} !== 33'd0) $display("FAIL store_rsp[%0d] got err=%b rdata=%h want 0/0", d, er, rd);
            else pass_cnt++;
            check_cnt++;
            if (n != lat_of(d) + 1) $display("FAIL store_lat[%0d] got %0d want %0d", d, n, lat_of(d) + 1);
            else pass_cnt++;
            do_req(d, 1'b0, 32'h10, 32'h0, 4'h0, rd, er, n);
            check_cnt++;
            if (rd !== 32'hDEADBEEF || er !== 1'b0)
                $display("FAIL load_data[%0d] got err=%b rdata=%h want 0/deadbeef", d, er, rd);
            else pass_cnt++;
            check_cnt++;
            if (n != lat_of(d) + 1) $display("FAIL load_lat[%0d] got %0d want %0d", d, n, lat_of(d) + 1);
            else pass_cnt++;
        end
    endtask

    task automatic test_byte_lanes();
        logic [31:0] rd; logic er; int n;
        for (int d = 0; d < 2; d++) begin
            do_req(d, 1'b1, 32'h10, 32'h000000AA, 4'b0001, rd, er, n);
            do_req(d, 1'b0, 32'h10, 32'h0, 4'h0, rd, er, n);
            check_cnt++;
            if (rd !== 32'hDEADBEAA) $display("FAIL be0001[%0d] got %h want deadbeaa", d, rd);
            else pass_cnt++;
            do_req(d, 1'b1, 32'h10, 32'h12345678, 4'b0000, rd, er, n);
            check_cnt++;
            if (er !== 1'b0) $display("FAIL be0000_err[%0d] got %b want 0", d, er);
            else pass_cnt++;
            do_req(d, 1'b0, 32'h10, 32'h0, 4'h0, rd, er, n);
            check_cnt++;
            if (rd !== 32'hDEADBEAA) $display("FAIL be0000[%0d] got %h want deadbeaa", d, rd);
            else pass_cnt++;
            do_req(d, 1'b1, 32'h10, 32'h11223344, 4'b1010, rd, er, n);
            do_req(d, 1'b0, 32'h10, 32'h0, 4'h0, rd, er, n);
            check_cnt++;
            if (rd !== 32'h11AD33AA) $display("FAIL be1010[%0d] got %h want 11ad33aa", d, rd);
            else pass_cnt++;
        end
    endtask

    task automatic test_errors();
        logic [31:0] rd; logic er; int n;
        for (int d = 0; d < 2; d++) begin
            do_req(d, 1'b0, 32'h13, 32'h0, 4'h0, rd, er, n);
            check_cnt++;
            if ({er, rd} !== {1'b1, 32'd0}) $display("FAIL misaligned[%0d] got err=%b rdata=%h want 1/0", d, er, rd);
            else pass_cnt++;
            do_req(d, 1'b0, 32'h1000, 32'h0, 4'h0, rd, er, n);
            check_cnt++;
            if ({er, rd} !== {1'b1, 32'd0}) $display("FAIL range[%0d] got err=%b rdata=%h want 1/0", d, er, rd);
            else pass_cnt++;
            // 0x1010 aliases word 4 if the range check were dropped
            do_req(d, 1'b1, 32'h1010, 32'hFFFFFFFF, 4'hF, rd, er, n);
            check_cnt++;
            if (er !== 1'b1) $display("FAIL range_store[%0d] got err=%b want 1", d, er);
            else pass_cnt++;
            do_req(d, 1'b1, 32'h11, 32'hFFFFFFFF, 4'hF, rd, er, n);
            check_cnt++;
            if (er !== 1'b1) $display("FAIL misal_store[%0d] got err=%b want 1", d, er);
            else pass_cnt++;
            do_req(d, 1'b0, 32'h10, 32'h0, 4'h0, rd, er, n);
            check_cnt++;
            if ({er, rd} !== {1'b0, 32'h11AD33AA})
                $display("FAIL err_noupdate[%0d] got err=%b rdata=%h want 0/11ad33aa", d, er, rd);
            else pass_cnt++;
        end
    endtask

    task automatic test_stall();
        logic [31:0] rd; logic er; int n;
        for (int d = 0; d < 2; d++) begin
            @(negedge clk);
            req_valid[d] = 1'b1; req_we[d] = 1'b0; req_addr[d] = 32'h10; req_be[d] = 4'h0;
            @(posedge clk); #1;
            req_valid[d] = 1'b0;
            n = 1;
            while (rsp_valid[d] !== 1'b1 && n < 40) begin
                @(posedge clk); #1;
                n++;
            end
            check_cnt++;
            if (n != lat_of(d) + 1) $display("FAIL stall_lat[%0d] got %0d want %0d", d, n, lat_of(d) + 1);
            else pass_cnt++;
            req_valid[d] = 1'b1; req_we[d] = 1'b1; req_addr[d] = 32'h14;
            req_wdata[d] = 32'hCAFEF00D; req_be[d] = 4'hF;
            for (int c = 0; c < 5; c++) begin
                @(posedge clk); #1;
                check_cnt++;
                if ({rsp_valid[d], rsp_err[d], req_ready[d], busy[d]} !== 4'b1001 || rsp_rdata[d] !== 32'h11AD33AA)
                    $display("FAIL stall_hold[%0d] cyc %0d got valid/err/ready/busy=%b rdata=%h want 1001/11ad33aa",
                             d, c, {rsp_valid[d], rsp_err[d], req_ready[d], busy[d]}, rsp_rdata[d]);
                else pass_cnt++;
            end
            rsp_ready[d] = 1'b1;
            @(posedge clk); #1;
            rsp_ready[d] = 1'b0;
            check_cnt++;
            if ({rsp_valid[d], req_ready[d], busy[d], rsp_rdata[d]} !== {3'b010, 32'd0})
                $display("FAIL stall_retire[%0d] got valid/ready/busy=%b rdata=%h want 010/0", d,
                         {rsp_valid[d], req_ready[d], busy[d]}, rsp_rdata[d]);
            else pass_cnt++;
            @(posedge clk); #1;
            req_valid[d] = 1'b0;
            n = 1;
            while (rsp_valid[d] !== 1'b1 && n < 40) begin
                @(posedge clk); #1;
                n++;
            end
            check_cnt++;
            if (n != lat_of(d) + 1) $display("FAIL held_lat[%0d] got %0d want %0d", d, n, lat_of(d) + 1);
            else pass_cnt++;
            rsp_ready[d] = 1'b1;
            @(posedge clk); #1;
            rsp_ready[d] = 1'b0;
            do_req(d, 1'b0, 32'h14, 32'h0, 4'h0, rd, er, n);
            check_cnt++;
            if (rd !== 32'hCAFEF00D) $display("FAIL held_store[%0d] got %h want cafef00d", d, rd);
            else pass_cnt++;
        end
    endtask

    task automatic test_reset_abort();
        logic [31:0] rd; logic er; int n;
        for (int d = 0; d < 2; d++) begin
            do_req(d, 1'b1, 32'h20, 32'h11111111, 4'hF, rd, er, n);
            @(negedge clk);
            req_valid[d] = 1'b1; req_we[d] = 1'b1; req_addr[d] = 32'h20;
            req_wdata[d] = 32'h22222222; req_be[d] = 4'hF;
            @(posedge clk); #1;
            req_valid[d] = 1'b0;
            rst[d] = 1'b0;
            #1;
            check_cnt++;
            if ({rsp_valid[d], busy[d], req_ready[d]} !== 3'b000)
                $display("FAIL abort_state[%0d] got valid/busy/ready=%b want 000", d,
                         {rsp_valid[d], busy[d], req_ready[d]});
            else pass_cnt++;
            @(posedge clk);
            @(negedge clk);
            rst[d] = 1'b1;
            do_req(d, 1'b0, 32'h20, 32'h0, 4'h0, rd, er, n);
            check_cnt++;
            if (rd !== ((lat_of(d) > 0) ? 32'h11111111 : 32'h22222222))
                $display("FAIL abort_data[%0d] got %h want %h", d, rd,
                         (lat_of(d) > 0) ? 32'h11111111 : 32'h22222222);
            else pass_cnt++;
        end
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_byte_lanes();
        test_errors();
        test_stall();
        test_reset_abort();
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
